// File: rtl/axis_spi_master_if.sv
// AXI-stream word channel shared by the SPI master's input and output sides.
// Signals: tdata/tvalid/tlast flow master->slave, tready flows slave->master.
interface axis_spi_master_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_spi_master.sv
// AXI-stream to SPI mode-0 master: one stream word in, one sampled word out.
// Ports: clk, rst_n, input_axis (slave), output_axis (master), prescale,
//        cs (active low), sck, mosi, miso, busy.
module axis_spi_master #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  axis_spi_master_if.slave          input_axis,
  axis_spi_master_if.master         output_axis,
  input  logic [15:0]               prescale,
  output logic                      cs,
  output logic                      sck,
  output logic                      mosi,
  input  logic                      miso,
  output logic                      busy
);

  localparam logic [4:0] NBITS = 5'(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_NEXT,
    SCK_LOW,
    SCK_HIGH,
    CS_HOLD,
    CS_GAP
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           p_q, p_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] od_q, od_d;
  logic [4:0]            bit_q, bit_d;
  logic                  last_q, last_d;
  logic                  ov_q, ov_d;
  logic                  ol_q, ol_d;
  logic                  cs_q, cs_d;
  logic                  sck_q, sck_d;
  logic                  mosi_q, mosi_d;

  logic                  accept;
  logic                  hs;
  logic                  cnt_done;
  logic [4:0]            bit_nx;

  // Gated by rst_n so tready stays low while reset is held.
  assign accept = rst_n & ~ov_q &
                  ((state_q == IDLE) | (state_q == WAIT_NEXT));
  assign hs       = accept & input_axis.tvalid;
  assign cnt_done = (cnt_q == p_q - 16'd1);
  assign bit_nx   = bit_q + 5'd1;

  assign input_axis.tready  = accept;
  assign output_axis.tdata  = od_q;
  assign output_axis.tvalid = ov_q;
  assign output_axis.tlast  = ol_q;
  assign cs   = cs_q;
  assign sck  = sck_q;
  assign mosi = mosi_q;
  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      od_q    <= '0;
      bit_q   <= '0;
      last_q  <= 1'b0;
      ov_q    <= 1'b0;
      ol_q    <= 1'b0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      od_q    <= od_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      ov_q    <= ov_d;
      ol_q    <= ol_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    p_d     = p_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    od_d    = od_q;
    bit_d   = bit_q;
    last_d  = last_q;
    ov_d    = ov_q;
    ol_d    = ol_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;

    if (ov_q && output_axis.tready) begin
      ov_d = 1'b0;
    end

    unique case (state_q)
      IDLE, WAIT_NEXT: begin
        cnt_d = '0;
        if (hs) begin
          tx_d    = input_axis.tdata;
          last_d  = input_axis.tlast;
          p_d     = (prescale == 16'd0) ? 16'd1 : prescale;
          rx_d    = '0;
          bit_d   = '0;
          cs_d    = 1'b0;
          sck_d   = 1'b0;
          mosi_d  = input_axis.tdata[DATA_WIDTH-1];
          state_d = SCK_LOW;
        end
      end
      SCK_LOW: begin
        if (cnt_done) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          rx_d    = {rx_q[DATA_WIDTH-2:0], miso};
          state_d = SCK_HIGH;
        end
      end
      SCK_HIGH: begin
        if (cnt_done) begin
          cnt_d = '0;
          sck_d = 1'b0;
          bit_d = bit_nx;
          if (bit_nx < NBITS) begin
            tx_d    = tx_q << 1;
            mosi_d  = tx_q[DATA_WIDTH-2];
            state_d = SCK_LOW;
          end else begin
            od_d    = rx_q;
            ov_d    = 1'b1;
            ol_d    = last_q;
            mosi_d  = 1'b0;
            state_d = last_q ? CS_HOLD : WAIT_NEXT;
          end
        end
      end
      CS_HOLD: begin
        if (cnt_done) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          state_d = CS_GAP;
        end
      end
      CS_GAP: begin
        if (cnt_done) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axis_spi_master.sv
// Randomized scoreboard bench for axis_spi_master with an SPI slave model.
// Ports of the DUT are all driven/observed here; summary line at the end.
module tb_axis_spi_master;

  localparam int DW = 8;

  typedef struct {
    int cslow;
    int rises;
    int hi;
  } fexp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] prescale = 16'd1;
  logic        cs, sck, mosi, busy;
  logic        miso = 1'b0;

  axis_spi_master_if #(.DATA_WIDTH(DW)) in_if ();
  axis_spi_master_if #(.DATA_WIDTH(DW)) out_if ();

  axis_spi_master #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .input_axis  (in_if.slave),
    .output_axis (out_if.master),
    .prescale    (prescale),
    .cs          (cs),
    .sck         (sck),
    .mosi        (mosi),
    .miso        (miso),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW:0]   exp_out[$];
  logic [DW-1:0] exp_mosi[$];
  logic [DW-1:0] slave_q[$];
  fexp_t         exp_frame[$];

  int rises = 0;
  int mode = 0;

  task automatic check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  // Downstream ready, changed just after the edge so it is stable at negedge.
  always @(posedge clk) begin
    #1;
    case (mode)
      0: out_if.tready = 1'b1;
      1: out_if.tready = 1'($urandom_range(0, 1));
      default: out_if.tready = 1'b0;
    endcase
  end

  // SPI slave: supplies head of slave_q MSB first, collects mosi.
  int            s_idx = 0;
  logic          s_psck = 1'b0;
  logic          s_pmosi = 1'b0;
  logic [DW-1:0] s_acc = '0;
  logic [DW-1:0] s_w;
  always @(negedge clk) begin
    if (!rst_n) begin
      s_idx = 0;
      s_psck = 1'b0;
      s_pmosi = 1'b0;
      miso = 1'b0;
    end else begin
      if (sck && s_psck) check("mosi_stable_high", mosi, s_pmosi);
      if (sck && !s_psck) begin
        s_acc = {s_acc[DW-2:0], mosi};
        s_idx++;
        if (s_idx == DW) begin
          s_idx = 0;
          if (exp_mosi.size() > 0) check("mosi_word", s_acc, exp_mosi.pop_front());
          else fail("mosi_unexpected");
          if (slave_q.size() > 0) void'(slave_q.pop_front());
        end
      end
      s_psck = sck;
      s_pmosi = mosi;
      if (slave_q.size() > 0) begin
        s_w = slave_q[0];
        miso = s_w[DW-1-s_idx];
      end else begin
        miso = 1'b0;
      end
    end
  end

  // Frame monitor: cs low length, sck edges and high widths.
  int    f_cs = 0;
  int    f_hi = 0;
  logic  f_pcs = 1'b1;
  logic  f_psck = 1'b0;
  fexp_t f_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      f_cs = 0;
      f_hi = 0;
      rises = 0;
      f_pcs = 1'b1;
      f_psck = 1'b0;
    end else begin
      if (!cs) f_cs++;
      if (sck) f_hi++;
      if (sck && !f_psck) rises++;
      if (!sck && f_psck) begin
        if (exp_frame.size() > 0) begin
          f_e = exp_frame[0];
          check("sck_high_width", f_hi, f_e.hi);
        end
        f_hi = 0;
      end
      if (cs && !f_pcs) begin
        if (exp_frame.size() > 0) begin
          f_e = exp_frame.pop_front();
          if (f_e.cslow >= 0) check("cs_low_cycles", f_cs, f_e.cslow);
          check("sck_rises", rises, f_e.rises);
        end else begin
          fail("frame_unexpected");
        end
        f_cs = 0;
        rises = 0;
      end
      f_pcs = cs;
      f_psck = sck;
    end
  end

  // Output monitor: scoreboard pop plus hold-while-stalled checks.
  logic          m_pv = 1'b0;
  logic          m_pr = 1'b0;
  logic          m_pl = 1'b0;
  logic [DW-1:0] m_pd = '0;
  logic [DW:0]   m_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_pv = 1'b0;
    end else begin
      if (m_pv && !m_pr) begin
        check("hold_valid", out_if.tvalid, 1);
        check("hold_data", out_if.tdata, m_pd);
        check("hold_last", out_if.tlast, m_pl);
      end
      if (out_if.tvalid && out_if.tready) begin
        if (exp_out.size() > 0) begin
          m_e = exp_out.pop_front();
          check("out_data", out_if.tdata, m_e[DW-1:0]);
          check("out_last", out_if.tlast, m_e[DW]);
        end else begin
          fail("out_unexpected");
        end
      end
      m_pv = out_if.tvalid;
      m_pr = out_if.tready;
      m_pd = out_if.tdata;
      m_pl = out_if.tlast;
    end
  end

  task automatic push_frame(int n, int ps);
    fexp_t f;
    int p;
    p = (ps == 0) ? 1 : ps;
    f.cslow = (n == 1) ? (2 * DW + 1) * p : -1;
    f.rises = n * DW;
    f.hi = p;
    exp_frame.push_back(f);
  endtask

  task automatic send_word(logic [DW-1:0] d, logic [DW-1:0] s,
                           logic last, logic [15:0] ps);
    int t;
    t = 0;
    exp_out.push_back({last, s});
    exp_mosi.push_back(d);
    slave_q.push_back(s);
    @(negedge clk);
    in_if.tdata = d;
    in_if.tlast = last;
    in_if.tvalid = 1'b1;
    prescale = ps;
    while (!in_if.tready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) fail("handshake_timeout");
    @(posedge clk);
    #1 in_if.tvalid = 1'b0;
  endtask

  task automatic send_frame(int n, int ps);
    push_frame(n, ps);
    for (int i = 0; i < n; i++)
      send_word(DW'($urandom), DW'($urandom), (i == n - 1), 16'(ps));
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || exp_out.size() > 0 || exp_frame.size() > 0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) fail("idle_timeout");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    in_if.tdata = '0;
    in_if.tvalid = 1'b0;
    in_if.tlast = 1'b0;
    out_if.tready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs", cs, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_tready", in_if.tready, 0);
    check("rst_ovalid", out_if.tvalid, 0);
    check("rst_odata", out_if.tdata, 0);
    check("rst_olast", out_if.tlast, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("idle_tready", in_if.tready, 1);

    // P=2 single word, slave returns 0x3C.
    push_frame(1, 2);
    send_word(8'hA5, 8'h3C, 1'b1, 16'd2);
    wait_idle();

    // P=1 three-word frame, cs held across words.
    push_frame(3, 1);
    send_word(8'h01, 8'h81, 1'b0, 16'd1);
    send_word(8'h02, 8'h42, 1'b0, 16'd1);
    send_word(8'h03, 8'h24, 1'b1, 16'd1);
    wait_idle();

    // Output stall between the two words of a frame.
    mode = 2;
    push_frame(2, 1);
    fork
      begin
        send_word(8'h5E, 8'hE7, 1'b0, 16'd1);
        send_word(8'h96, 8'h18, 1'b1, 16'd1);
      end
      begin
        t = 0;
        while (!out_if.tvalid && t < 1000) begin
          @(negedge clk);
          t++;
        end
        if (t >= 1000) fail("stall_wait_timeout");
        repeat (30) begin
          @(negedge clk);
          check("stall_tready", in_if.tready, 0);
          check("stall_cs", cs, 0);
          check("stall_sck", sck, 0);
        end
        mode = 0;
      end
    join
    wait_idle();

    // prescale 0 behaves as 1.
    push_frame(1, 0);
    send_word(8'hC6, 8'h6C, 1'b1, 16'd0);
    wait_idle();

    // prescale change mid-word is ignored until the next handshake.
    push_frame(1, 2);
    send_word(8'h39, 8'h93, 1'b1, 16'd2);
    repeat (6) @(negedge clk);
    prescale = 16'd5;
    wait_idle();
    push_frame(1, 5);
    send_word(8'h72, 8'h27, 1'b1, 16'd5);
    wait_idle();

    // Reset at the 4th sck rise aborts the word.
    push_frame(1, 2);
    send_word(8'h5A, 8'hC3, 1'b1, 16'd2);
    t = 0;
    while (rises < 4 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) fail("abort_wait_timeout");
    #2 rst_n = 1'b0;
    #1;
    check("abort_cs", cs, 1);
    check("abort_sck", sck, 0);
    check("abort_busy", busy, 0);
    check("abort_mosi", mosi, 0);
    check("abort_ovalid", out_if.tvalid, 0);
    exp_out.delete();
    exp_mosi.delete();
    slave_q.delete();
    exp_frame.delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_output", out_if.tvalid, 0);
    push_frame(1, 1);
    send_word(8'hFF, 8'hB1, 1'b1, 16'd1);
    wait_idle();

    // Random frames with random backpressure.
    mode = 1;
    for (int f = 0; f < 25; f++)
      send_frame(int'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
    wait_idle();
    mode = 0;
    repeat (5) @(negedge clk);
    check("final_out_queue", exp_out.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
